inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 133 +++++++++++++
 tb/tb_inst_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: loadable program store feeding a registered, stallable
// instruction output with halt, absolute/relative redirect and range checking.
//
// state | meaning
// IDLE  | after reset, program may be loaded, waiting for Start
// RUN   | fetching, one instruction per cycle while InstReady is high
// HALT  | stopped by Halt or an out-of-range fetch, program may be reloaded
module inst_fetch #(
   parameter int A_W   = 16,
   parameter int I_W   = 9,
   parameter int DEPTH = 1024,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [A_W-1:0]   StartAddr,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic             BranchRel,
   input  logic [A_W-1:0]   Target,
   input  logic             LoadEn,
   input  logic [A_W-1:0]   LoadAddr,
   input  logic [I_W-1:0]   LoadData,
   output logic [I_W-1:0]   InstOut,
   output logic [A_W-1:0]   InstAddr,
   output logic             InstValid,
   input  logic             InstReady,
   output logic             Busy,
   output logic             Done,
   output logic             OutOfRange,
   output logic [CNT_W-1:0] InstCount
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [A_W:0] DEPTH_X = (A_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t state, stateNext;
   logic [A_W-1:0] pc;
   logic [I_W-1:0] mem [DEPTH];

   logic pcInRange, loadInRange, accept;
   logic doStart, doHalt, doBranch, doFetch, doOor;

   assign pcInRange   = ({1'b0, pc} < DEPTH_X);
   assign loadInRange = ({1'b0, LoadAddr} < DEPTH_X);
   assign accept      = (state == RUN) && InstValid && InstReady;
   assign Busy        = (state == RUN);
   assign Done        = (state == HALT);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      doStart   = 1'b0;
      doHalt    = 1'b0;
      doBranch  = 1'b0;
      doFetch   = 1'b0;
      doOor     = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (Start) begin
               doStart   = 1'b1;
               stateNext = RUN;
            end
         end
         RUN: begin
            if (Halt) begin
               doHalt    = 1'b1;
               stateNext = HALT;
            end else if (BranchEn) begin
               doBranch = 1'b1;
            end else if (!InstValid || InstReady) begin
               if (pcInRange) begin
                  doFetch = 1'b1;
               end else begin
                  doOor     = 1'b1;
                  stateNext = HALT;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Program store has no reset so a loaded program survives Reset.
   always_ff @(posedge CLK) begin
      if (LoadEn && (state != RUN) && loadInRange)
         mem[LoadAddr[IDX_W-1:0]] <= LoadData;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc         <= '0;
         InstOut    <= '0;
         InstAddr   <= '0;
         InstValid  <= 1'b0;
         OutOfRange <= 1'b0;
         InstCount  <= '0;
      end else if (doStart) begin
         pc         <= StartAddr;
         InstValid  <= 1'b0;
         OutOfRange <= 1'b0;
         InstCount  <= '0;
      end else begin
         if (accept)
            InstCount <= InstCount + CNT_W'(1);
         if (doHalt)
            InstValid <= 1'b0;
         // Relative targets are offsets from the instruction being presented.
         if (doBranch) begin
            pc        <= BranchRel ? (InstAddr + Target) : Target;
            InstValid <= 1'b0;
         end
         if (doFetch) begin
            InstOut   <= mem[pc[IDX_W-1:0]];
            InstAddr  <= pc;
            InstValid <= 1'b1;
            pc        <= pc + A_W'(1);
         end
         if (doOor) begin
            InstValid  <= 1'b0;
            OutOfRange <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a default-depth instance for the main flow and
// a DEPTH=8 instance sharing the same stimulus for the range check.
module tb_inst_fetch;
   localparam int A_W   = 16;
   localparam int I_W   = 9;
   localparam int CNT_W = 32;

   logic CLK = 1'b0;
   logic Reset, Start, Halt, BranchEn, BranchRel, LoadEn, InstReady;
   logic [A_W-1:0] StartAddr, Target, LoadAddr;
   logic [I_W-1:0] LoadData;

   logic [I_W-1:0]   instOut, sInstOut;
   logic [A_W-1:0]   instAddr, sInstAddr;
   logic             instValid, busy, done, outOfRange;
   logic             sInstValid, sBusy, sDone, sOutOfRange;
   logic [CNT_W-1:0] instCount, sInstCount;

   logic [I_W-1:0] expMem [16];
   int nChecks = 0;
   int nFails  = 0;

   inst_fetch dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
      .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target),
      .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .InstOut(instOut), .InstAddr(instAddr), .InstValid(instValid), .InstReady(InstReady),
      .Busy(busy), .Done(done), .OutOfRange(outOfRange), .InstCount(instCount)
   );

   inst_fetch #(.DEPTH(8)) dutSmall (
      .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
      .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target),
      .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .InstOut(sInstOut), .InstAddr(sInstAddr), .InstValid(sInstValid), .InstReady(InstReady),
      .Busy(sBusy), .Done(sDone), .OutOfRange(sOutOfRange), .InstCount(sInstCount)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
      nChecks++;
      if (obs !== expVal) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expVal);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkPresent(input string tag, input int addr, input int cnt);
      chk({tag, ".valid"}, 32'(instValid), 32'd1);
      chk({tag, ".addr"},  32'(instAddr),  32'(addr));
      chk({tag, ".out"},   32'(instOut),   32'(expMem[addr]));
      chk({tag, ".count"}, 32'(instCount), 32'(cnt));
   endtask

   task automatic checkAllZero(input string tag);
      chk({tag, ".valid"}, 32'(instValid),  32'd0);
      chk({tag, ".addr"},  32'(instAddr),   32'd0);
      chk({tag, ".out"},   32'(instOut),    32'd0);
      chk({tag, ".count"}, 32'(instCount),  32'd0);
      chk({tag, ".busy"},  32'(busy),       32'd0);
      chk({tag, ".done"},  32'(done),       32'd0);
      chk({tag, ".oor"},   32'(outOfRange), 32'd0);
   endtask

   task automatic startAt(input int addr);
      StartAddr = A_W'(addr);
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic haltNow();
      Halt = 1'b1;
      step();
      Halt = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Halt = 1'b0; BranchEn = 1'b0; BranchRel = 1'b0;
      LoadEn = 1'b0; InstReady = 1'b0;
      StartAddr = '0; Target = '0; LoadAddr = '0; LoadData = '0;
      for (int i = 0; i < 16; i++)
         expMem[i] = (i < 5) ? I_W'(9'h011 + i) : I_W'(9'h100 + i);

      #3;
      checkAllZero("reset");
      step();
      step();
      Reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         LoadEn = 1'b1; LoadAddr = A_W'(i); LoadData = expMem[i];
         step();
      end
      LoadEn = 1'b0;

      // Sequential run from 0 with the consumer always ready
      InstReady = 1'b1;
      startAt(0);
      chk("seq.startBusy",  32'(busy),      32'd1);
      chk("seq.startValid", 32'(instValid), 32'd0);
      for (int k = 0; k <= 5; k++) begin
         step();
         checkPresent($sformatf("seq%0d", k), k, k);
      end
      haltNow();
      chk("seq.haltDone", 32'(done), 32'd1);
      chk("seq.haltBusy", 32'(busy), 32'd0);

      // Backpressure at address 2
      startAt(0);
      step(); step(); step();
      checkPresent("bp.pre", 2, 2);
      InstReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checkPresent($sformatf("bp.stall%0d", k), 2, 2);
      end
      InstReady = 1'b1;
      step();
      checkPresent("bp.resume3", 3, 3);
      step();
      checkPresent("bp.resume4", 4, 4);
      haltNow();

      // Absolute branch from address 1, then relative -2 from address 10
      startAt(0);
      step(); step();
      checkPresent("br.pre", 1, 1);
      BranchEn = 1'b1; BranchRel = 1'b0; Target = 16'd8;
      step();
      BranchEn = 1'b0;
      chk("br.absBubble", 32'(instValid), 32'd0);
      chk("br.absCount",  32'(instCount), 32'd2);
      step();
      checkPresent("br.abs8", 8, 2);
      step(); step();
      checkPresent("br.pre10", 10, 4);
      BranchEn = 1'b1; BranchRel = 1'b1; Target = 16'hFFFE;
      step();
      BranchEn = 1'b0;
      chk("br.relBubble", 32'(instValid), 32'd0);
      step();
      checkPresent("br.rel8", 8, 5);

      // Halt wins over a simultaneous branch
      Halt = 1'b1; BranchEn = 1'b1; BranchRel = 1'b0; Target = 16'd0;
      step();
      Halt = 1'b0; BranchEn = 1'b0;
      chk("hb.done",  32'(done),      32'd1);
      chk("hb.valid", 32'(instValid), 32'd0);
      chk("hb.pc",    32'(dut.pc),    32'd9);
      step();
      chk("hb.idleValid", 32'(instValid), 32'd0);
      startAt(3);
      chk("hb.startCount", 32'(instCount), 32'd0);
      step();
      checkPresent("hb.start3", 3, 0);
      haltNow();

      // Range check on the DEPTH=8 instance, load guard on the main one
      startAt(6);
      chk("rng.oorCleared", 32'(sOutOfRange), 32'd0);
      step();
      chk("rng.addr6", 32'(sInstAddr), 32'd6);
      chk("rng.out6",  32'(sInstOut),  32'(expMem[6]));
      step();
      chk("rng.addr7", 32'(sInstAddr), 32'd7);
      chk("rng.out7",  32'(sInstOut),  32'(expMem[7]));
      step();
      chk("rng.valid", 32'(sInstValid),  32'd0);
      chk("rng.oor",   32'(sOutOfRange), 32'd1);
      chk("rng.done",  32'(sDone),       32'd1);
      checkPresent("ld.pre8", 8, 2);
      LoadEn = 1'b1; LoadAddr = 16'd12; LoadData = 9'h1FF;
      step();
      LoadEn = 1'b0;
      step(); step(); step();
      checkPresent("ld.guard12", 12, 6);

      // Asynchronous reset in the middle of a presented instruction
      #2;
      Reset = 1'b1;
      #1;
      checkAllZero("arst");
      step();
      Reset = 1'b0;
      step();
      chk("arst.idleBusy", 32'(busy), 32'd0);
      startAt(0);
      step();
      checkPresent("arst.reload0", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
